// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: boot/run sequencing, prioritised redirects with
// alignment checking, and a circular return-address stack for call/return prediction.
module fetch_pc_unit #(
  parameter int                 WIDTH_P        = 32,
  parameter logic [WIDTH_P-1:0] RESET_VECTOR_P = '0,
  parameter int                 RAS_DEPTH_P    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               take_branch_i,
  input  logic [WIDTH_P-1:0] branch_target_i,
  input  logic               is_jalr_i,
  input  logic [WIDTH_P-1:0] jalr_target_i,
  input  logic               trap_i,
  input  logic [WIDTH_P-1:0] trap_vector_i,
  input  logic               ras_push_i,
  input  logic [WIDTH_P-1:0] ras_push_addr_i,
  input  logic               ras_pop_i,
  input  logic               fetch_ready_i,
  output logic               fetch_valid_o,
  output logic [WIDTH_P-1:0] pc_o,
  output logic               redirect_o,
  output logic               misaligned_o,
  output logic               ras_empty_o,
  output logic               ras_full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH_P);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [WIDTH_P-1:0] pc;
  logic               redirect;
  logic               misaligned;
  logic [PTR_W-1:0]   top;
  logic [CNT_W-1:0]   count;
  logic [WIDTH_P-1:0] ras [RAS_DEPTH_P];

  logic [PTR_W-1:0]   top_prev;
  logic [WIDTH_P-1:0] ras_top_entry;
  logic               ras_nonempty;
  logic               ras_is_full;

  logic               sel_valid;
  logic               sel_check;
  logic               sel_pop;
  logic [WIDTH_P-1:0] sel_target;
  logic               target_bad;
  logic               take_redirect;
  logic               do_pop;
  logic               advance;
  logic [WIDTH_P-1:0] pc_next;

  // top points at the next free slot, so the most recent entry sits one below it
  assign top_prev      = top - PTR_W'(1);
  assign ras_top_entry = ras[top_prev];
  assign ras_nonempty  = (count != '0);
  assign ras_is_full   = (count == CNT_W'(RAS_DEPTH_P));

  always_comb begin
    sel_valid  = 1'b0;
    sel_check  = 1'b0;
    sel_pop    = 1'b0;
    sel_target = '0;
    if (state == RUN) begin
      if (trap_i) begin
        sel_valid  = 1'b1;
        sel_target = trap_vector_i;
      end else if (is_jalr_i) begin
        sel_valid  = 1'b1;
        sel_check  = 1'b1;
        sel_target = {jalr_target_i[WIDTH_P-1:1], 1'b0};
      end else if (take_branch_i) begin
        sel_valid  = 1'b1;
        sel_check  = 1'b1;
        sel_target = branch_target_i;
      end else if (ras_pop_i && ras_nonempty) begin
        sel_valid  = 1'b1;
        sel_check  = 1'b1;
        sel_pop    = 1'b1;
        sel_target = ras_top_entry;
      end
    end
  end

  // A rejected redirect still suppresses the sequential advance
  assign target_bad    = sel_check && (sel_target[1:0] != 2'b00);
  assign take_redirect = sel_valid && !target_bad;
  assign do_pop        = take_redirect && sel_pop;
  assign advance       = (state == RUN) && !sel_valid && fetch_ready_i && !stall_i;

  always_comb begin
    pc_next = pc;
    if (take_redirect) begin
      pc_next = sel_target;
    end else if (advance) begin
      pc_next = pc + WIDTH_P'(4);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR_P;
      redirect   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= RUN;
      pc         <= pc_next;
      redirect   <= take_redirect;
      misaligned <= sel_valid && target_bad;
    end
  end

  // Push+pop together replaces the top in place, so pointer and count stay put
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      top   <= '0;
      count <= '0;
    end else if (ras_push_i && do_pop) begin
      top   <= top;
      count <= count;
    end else if (do_pop) begin
      top   <= top_prev;
      count <= count - CNT_W'(1);
    end else if (ras_push_i) begin
      top <= top + PTR_W'(1);
      if (!ras_is_full) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ras_push_i) begin
      if (do_pop) begin
        ras[top_prev] <= ras_push_addr_i;
      end else begin
        ras[top] <= ras_push_addr_i;
      end
    end
  end

  assign fetch_valid_o = (state == RUN);
  assign pc_o          = pc;
  assign redirect_o    = redirect;
  assign misaligned_o  = misaligned;
  assign ras_empty_o   = !ras_nonempty;
  assign ras_full_o    = ras_is_full;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios against literal values
// plus a randomized run against a queue-based behavioural model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RV = 32'h100;
  localparam int DEPTH = 4;

  logic        clk, rst, stall, take_branch, is_jalr, trap, ras_push, ras_pop, fetch_ready;
  logic [31:0] branch_target, jalr_target, trap_vector, ras_push_addr;
  logic        fetch_valid, redirect, misaligned, ras_empty, ras_full;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] pc_m;
  logic        boot_m, red_m, mis_m;
  logic [31:0] ras_m[$];

  fetch_pc_unit #(.WIDTH_P(32), .RESET_VECTOR_P(RV), .RAS_DEPTH_P(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .take_branch_i(take_branch), .branch_target_i(branch_target),
    .is_jalr_i(is_jalr), .jalr_target_i(jalr_target),
    .trap_i(trap), .trap_vector_i(trap_vector),
    .ras_push_i(ras_push), .ras_push_addr_i(ras_push_addr),
    .ras_pop_i(ras_pop), .fetch_ready_i(fetch_ready),
    .fetch_valid_o(fetch_valid), .pc_o(pc), .redirect_o(redirect),
    .misaligned_o(misaligned), .ras_empty_o(ras_empty), .ras_full_o(ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    stall = 0; take_branch = 0; is_jalr = 0; trap = 0; ras_push = 0; ras_pop = 0;
    fetch_ready = 0; branch_target = 0; jalr_target = 0; trap_vector = 0; ras_push_addr = 0;
  endtask

  task automatic model_reset();
    pc_m = RV; boot_m = 1; red_m = 0; mis_m = 0;
    ras_m.delete();
  endtask

  // One clock edge: the model evaluates the spec rules on the current inputs
  task automatic tick();
    logic [31:0] pc_n, tgt;
    logic red_n, mis_n, has, chk, from_pop, pop_eff;
    pc_n = pc_m; red_n = 0; mis_n = 0; has = 0; chk = 0; from_pop = 0; pop_eff = 0; tgt = 0;
    if (!boot_m) begin
      if (trap) begin has = 1; tgt = trap_vector; end
      else if (is_jalr) begin has = 1; chk = 1; tgt = jalr_target & 32'hFFFF_FFFE; end
      else if (take_branch) begin has = 1; chk = 1; tgt = branch_target; end
      else if (ras_pop && ras_m.size() > 0) begin
        has = 1; chk = 1; from_pop = 1; tgt = ras_m[ras_m.size()-1];
      end
      if (has) begin
        if (chk && (tgt % 4 != 0)) mis_n = 1;
        else begin pc_n = tgt; red_n = 1; pop_eff = from_pop; end
      end else if (fetch_ready && !stall) begin
        pc_n = pc_m + 32'd4;
      end
    end
    @(posedge clk); #1;
    if (rst) begin
      model_reset();
    end else begin
      if (ras_push && pop_eff) ras_m[ras_m.size()-1] = ras_push_addr;
      else if (pop_eff) void'(ras_m.pop_back());
      else if (ras_push) begin
        ras_m.push_back(ras_push_addr);
        if (ras_m.size() > DEPTH) void'(ras_m.pop_front());
      end
      pc_m = pc_n; red_m = red_n; mis_m = mis_n; boot_m = 0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4];
    logic        exp_v  [4];
    exp_pc = '{32'h100, 32'h100, 32'h104, 32'h108};
    exp_v  = '{1'b0, 1'b1, 1'b1, 1'b1};
    clear_inputs();
    rst = 1; model_reset();
    @(posedge clk); #1;
    rst = 0;
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", ras_empty); end
    n_checks++; if (ras_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", ras_full); end
    n_checks++; if (redirect !== 1'b0 || misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pulses: got red=%b mis=%b expected 0 0", redirect, misaligned); end
    fetch_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_checks++; if (pc !== exp_pc[i]) begin n_fail++; $display("[TB] FAIL boot_pc[%0d]: got %h expected %h", i, pc, exp_pc[i]); end
      n_checks++; if (fetch_valid !== exp_v[i]) begin n_fail++; $display("[TB] FAIL boot_valid[%0d]: got %b expected %b", i, fetch_valid, exp_v[i]); end
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    trap = 1; trap_vector = 32'h800; is_jalr = 1; jalr_target = 32'h2001;
    take_branch = 1; branch_target = 32'h300;
    tick();
    n_checks++; if (pc !== 32'h800) begin n_fail++; $display("[TB] FAIL prio_trap_pc: got %h expected 800", pc); end
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("[TB] FAIL prio_trap_red: got %b expected 1", redirect); end
    clear_inputs();
    tick();
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_red_pulse: got %b expected 0", redirect); end
    is_jalr = 1; jalr_target = 32'h2001; take_branch = 1; branch_target = 32'h300;
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h2000) begin n_fail++; $display("[TB] FAIL prio_jalr_pc: got %h expected 2000", pc); end
  endtask

  task automatic test_misaligned();
    clear_inputs();
    take_branch = 1; branch_target = 32'h302; fetch_ready = 1;
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h2000) begin n_fail++; $display("[TB] FAIL mis_pc: got %h expected 2000", pc); end
    n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_pulse: got %b expected 1", misaligned); end
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_red: got %b expected 0", redirect); end
    tick();
    n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_clear: got %b expected 0", misaligned); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_pop [4];
    exp_pop = '{32'h50, 32'h40, 32'h30, 32'h20};
    clear_inputs();
    for (int i = 1; i <= 5; i++) begin
      ras_push = 1; ras_push_addr = 32'h10 * i;
      tick();
    end
    clear_inputs();
    n_checks++; if (ras_full !== 1'b1) begin n_fail++; $display("[TB] FAIL ras_full: got %b expected 1", ras_full); end
    for (int i = 0; i < 4; i++) begin
      ras_pop = 1;
      tick();
      n_checks++; if (pc !== exp_pop[i] || redirect !== 1'b1) begin n_fail++; $display("[TB] FAIL ras_pop[%0d]: got pc=%h red=%b expected pc=%h red=1", i, pc, redirect, exp_pop[i]); end
    end
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h20 || redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL ras_pop_empty: got pc=%h red=%b expected pc=20 red=0", pc, redirect); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL ras_empty: got %b expected 1", ras_empty); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_seq [3];
    exp_seq = '{32'h700, 32'h900, 32'h600};
    clear_inputs();
    ras_push = 1; ras_push_addr = 32'h600; tick();
    ras_push_addr = 32'h700; tick();
    ras_push_addr = 32'h900; ras_pop = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ras_push = 0;
      n_checks++; if (pc !== exp_seq[i]) begin n_fail++; $display("[TB] FAIL pushpop_pc[%0d]: got %h expected %h", i, pc, exp_seq[i]); end
    end
    clear_inputs();
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL pushpop_empty: got %b expected 1", ras_empty); end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    clear_inputs();
    fetch_ready = 1; stall = 1;
    held = pc;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc !== held) begin n_fail++; $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i, pc, held); end
    end
    take_branch = 1; branch_target = 32'h400;
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h400) begin n_fail++; $display("[TB] FAIL stall_branch: got %h expected 400", pc); end
  endtask

  task automatic test_wrap();
    clear_inputs();
    take_branch = 1; branch_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    fetch_ready = 1;
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h expected 0", pc); end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    ras_push = 1; ras_push_addr = 32'hA00; fetch_ready = 1;
    tick(); tick();
    clear_inputs();
    take_branch = 1; branch_target = 32'h400;
    #2 rst = 1;
    #1;
    n_checks++; if (pc !== RV) begin n_fail++; $display("[TB] FAIL arst_pc: got %h expected %h", pc, RV); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_valid: got %b expected 0", fetch_valid); end
    n_checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_ras: got empty=%b full=%b expected 1 0", ras_empty, ras_full); end
    clear_inputs();
    tick();
    rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      trap        = ($urandom_range(0, 99) < 3);
      is_jalr     = ($urandom_range(0, 99) < 5);
      take_branch = ($urandom_range(0, 99) < 8);
      ras_pop     = ($urandom_range(0, 99) < 15);
      ras_push    = ($urandom_range(0, 99) < 20);
      stall       = ($urandom_range(0, 99) < 25);
      fetch_ready = ($urandom_range(0, 99) < 75);
      r = $urandom; trap_vector   = r;
      r = $urandom; branch_target = (r & 32'hFFFF_FFFC) | (($urandom_range(0, 9) == 0) ? 32'(r[1:0]) : 32'd0);
      r = $urandom; jalr_target   = (r & 32'hFFFF_FFFD) | (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
      r = $urandom; ras_push_addr = (r & 32'hFFFF_FFFC) | (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
      tick();
      n_checks++; if (pc !== pc_m) begin n_fail++; $display("[TB] FAIL rnd_pc[%0d]: got %h expected %h", i, pc, pc_m); end
      n_checks++; if (fetch_valid !== !boot_m) begin n_fail++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, fetch_valid, !boot_m); end
      n_checks++; if (redirect !== red_m) begin n_fail++; $display("[TB] FAIL rnd_red[%0d]: got %b expected %b", i, redirect, red_m); end
      n_checks++; if (misaligned !== mis_m) begin n_fail++; $display("[TB] FAIL rnd_mis[%0d]: got %b expected %b", i, misaligned, mis_m); end
      n_checks++; if (ras_empty !== (ras_m.size() == 0)) begin n_fail++; $display("[TB] FAIL rnd_empty[%0d]: got %b expected %b", i, ras_empty, ras_m.size() == 0); end
      n_checks++; if (ras_full !== (ras_m.size() == DEPTH)) begin n_fail++; $display("[TB] FAIL rnd_full[%0d]: got %b expected %b", i, ras_full, ras_m.size() == DEPTH); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    model_reset();
    $display("[TB] starting fetch_pc_unit bench");
    test_reset();
    test_priority();
    test_misaligned();
    test_ras();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter: WIDTH_P, 32, address width in bits (>= 8).
REQ-002 Parameter: RESET_VECTOR_P, 0, PC value loaded on reset (must be 4-byte aligned).
REQ-003 Parameter: RAS_DEPTH_P, 4, return-address-stack entries (power of two, >= 2).
REQ-004 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_i  in  1  reset, asynchronous and active-high.
REQ-006 Port: stall_i  in  1  hold the sequential PC advance.
REQ-007 Port: take_branch_i  in  1 and branch_target_i  in  WIDTH_P  branch/JAL redirect and its target.
REQ-008 Port: is_jalr_i  in  1 and jalr_target_i  in  WIDTH_P  JALR redirect and its raw ALU result.
REQ-009 Port: trap_i  in  1 and trap_vector_i  in  WIDTH_P  trap redirect and its handler address.
REQ-010 Port: ras_push_i  in  1 and ras_push_addr_i  in  WIDTH_P  call detected; return address to push.
REQ-011 Port: ras_pop_i  in  1  return detected; redirect to the popped RAS entry.
REQ-012 Port: fetch_ready_i  in  1  instruction memory accepts pc_o.
REQ-013 Port: fetch_valid_o  out  1  pc_o is a valid fetch request.
REQ-014 Port: pc_o  out  WIDTH_P  current fetch address.
REQ-015 Port: redirect_o  out  1  one-cycle pulse: the PC was redirected on the previous edge.
REQ-016 Port: misaligned_o  out  1  one-cycle pulse: a redirect was rejected as misaligned.
REQ-017 Port: ras_empty_o  out  1 and ras_full_o  out  1  RAS occupancy flags.

Function
REQ-018 FSM has two states. BOOT: entered on reset, lasts exactly one cycle, fetch_valid_o=0. RUN: fetch_valid_o=1. BOOT transitions to RUN unconditionally.
REQ-019 Redirect priority: trap_i > is_jalr_i > take_branch_i > ras_pop_i with RAS non-empty > sequential. Redirects are evaluated in RUN only.
REQ-020 Targets by source:
  - trap: trap_vector_i.
  - jalr: jalr_target_i with bit 0 cleared.
  - branch: branch_target_i.
  - ras pop: the top RAS entry.
REQ-021 If the selected target has bits[1:0] != 0 after masking:
  - pc_o holds;
  - misaligned_o pulses next cycle;
  - redirect_o stays 0;
  - no RAS pop occurs.
  A trap target is never checked.
REQ-022 An accepted redirect loads pc_o on the next edge and pulses redirect_o for one cycle. It applies regardless of stall_i and fetch_ready_i.
REQ-023 With no redirect: pc_o advances by 4 only when fetch_valid_o && fetch_ready_i && !stall_i; otherwise pc_o holds.
REQ-024 PC arithmetic is modulo 2^WIDTH_P; all-ones-minus-3 + 4 wraps to 0.
REQ-025 RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH_P).
REQ-026 RAS push, not full: write the entry, top+1, count+1.
REQ-027 RAS push, full: overwrite the oldest entry, top wraps, count stays RAS_DEPTH_P.
REQ-028 RAS pop, non-empty and used as the redirect: top-1, count-1.
REQ-029 ras_pop_i while empty is ignored: no redirect, no state change.
REQ-030 ras_pop_i that loses priority to a higher source does not pop.
REQ-031 Simultaneous push and effective pop: the top entry is replaced by ras_push_addr_i; count is unchanged; the redirect uses the old top value.
REQ-032 ras_push_i is honoured in both FSM states and independent of stall_i.
REQ-033 ras_empty_o = (count==0); ras_full_o = (count==RAS_DEPTH_P); both are registered-state derived with no input combinational path.

Reset
REQ-034 Assertion of rst_i, at any time including mid-redirect, asynchronously forces:
  - pc_o = RESET_VECTOR_P;
  - FSM to BOOT;
  - fetch_valid_o = 0, redirect_o = 0, misaligned_o = 0;
  - RAS count = 0 and top pointer = 0;
  - ras_empty_o = 1, ras_full_o = 0.
REQ-035 RAS entry contents are not reset. After rst_i deasserts, the first edge moves the FSM to RUN with pc_o unchanged.

Verification
REQ-036 Reset then fetch_ready_i=1, no stalls, RESET_VECTOR_P=0x100 -> pc_o = 0x100, 0x100, 0x104, 0x108; fetch_valid_o = 0, 1, 1, 1.
REQ-037 In one cycle assert trap_i (vector 0x800), is_jalr_i (target 0x2001), take_branch_i (0x300) -> pc_o = 0x800 next cycle, redirect_o pulses once. Repeat with jalr and branch only -> pc_o = 0x2000.
REQ-038 take_branch_i with target 0x302 -> pc_o unchanged, misaligned_o = 1 for one cycle, redirect_o = 0.
REQ-039 RAS_DEPTH_P=4; push 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full_o = 1. Five pops redirect to 0x50, 0x40, 0x30, 0x20 then no redirect; ras_empty_o = 1.
REQ-040 stall_i=1 with fetch_ready_i=1 holds pc_o for 3 cycles; a branch to 0x400 during the stall -> pc_o = 0x400 next cycle.
REQ-041 Assert rst_i asynchronously between edges, during a pending redirect -> pc_o = RESET_VECTOR_P and fetch_valid_o = 0 immediately; RAS empty.
